lsu: RTL
========

Name: lsu

Overview:
- Multi-cycle load/store unit between the decode stage and a handshaked data-memory bus.
- Replaces the combinational single-cycle memory path; generalised to XLEN 32/64.
- Adds valid/ready handshakes on both sides, a misalignment check with an error response, and bus-error propagation.
- Performs byte-lane steering for stores, plus lane extraction and sign/zero extension for loads.

Parameters:
XLEN, 32, data width; legal values 32 or 64.
ADDR_W, 32, address width.
MASK_W, XLEN/8, byte-mask width (derived; do not override).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
req_valid  in  1  decode presents a memory op
req_ready  out  1  LSU accepts an op
req_is_store  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=double
req_unsigned  in  1  zero-extend load (lbu/lhu/lwu)
req_addr  in  ADDR_W  effective byte address
req_wdata  in  XLEN  store data, LSB-aligned
resp_valid  out  1  result/completion available
resp_ready  in  1  consumer takes the response
resp_rdata  out  XLEN  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, illegal size, or bus error
mem_req_valid  out  1  bus request
mem_req_ready  in  1  bus accepts request
mem_addr  out  ADDR_W  req_addr aligned down to an MASK_W boundary
mem_wen  out  1  write request
mem_wdata  out  XLEN  lane-shifted store data
mem_wmask  out  MASK_W  byte enables; all-ones for loads
mem_rsp_valid  in  1  bus response
mem_rsp_rdata  in  XLEN  bus read data
mem_rsp_err  in  1  bus error

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous, active-low, on rst. On rst=0 at a clk edge:
  - state returns to IDLE;
  - req_ready, resp_valid, mem_req_valid, resp_err and mem_wen are 0;
  - resp_rdata, mem_addr, mem_wdata and mem_wmask are 0.
- Reset mid-operation: abandons the transaction without a response. A bus response arriving afterwards is ignored.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1 only in this state.
  - On req_valid&req_ready, all req_* fields are latched.
  - Misaligned: addr mod (1<<size) != 0.
  - Illegal size: size==3 with XLEN==32.
  - Misaligned or illegal -> RESP with resp_err=1, resp_rdata=0, and no bus transaction.
  - Otherwise -> REQ.
- REQ:
  - mem_req_valid=1 from the cycle after acceptance.
  - mem_addr, mem_wen, mem_wdata and mem_wmask stay stable until mem_req_ready.
  - On mem_req_valid&mem_req_ready -> WAIT; mem_req_valid drops the next cycle.
- WAIT:
  - mem_rsp_valid is sampled only in this state; a response in the REQ handshake cycle is not legal for the bus.
  - On mem_rsp_valid, register resp_err=mem_rsp_err and resp_rdata (load, no error) -> RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held until resp_ready.
  - On resp_valid&resp_ready -> IDLE.
  - No new request is accepted in the same cycle (req_ready=0 in RESP).
- Store steering:
  - off = addr[log2(MASK_W)-1:0].
  - mem_wmask = ((1<<(1<<size))-1) << off.
  - mem_wdata = req_wdata << (8*off); bits outside the mask are don't-care and are driven as the shifted value.
- Load extract: lane = mem_rsp_rdata >> (8*off), truncated to 8<<size bits. The lane is sign-extended unless req_unsigned or size==log2(MASK_W); full width passes through.
- Minimum latency, with the bus ready immediately and a response one cycle after the handshake:
  - accept at cycle 0;
  - mem_req_valid at cycle 1;
  - mem_rsp_valid at cycle 2;
  - resp_valid at cycle 3.
- Error latency: resp_valid at cycle 1.
- Size and alignment checks use only the latched values; req_* may change after acceptance.

Test Plan:
- XLEN=32, store byte, addr=0x8000_0003, wdata=0x0000_00A5 -> mem_addr=0x8000_0000, wmask=4'b1000, wdata[31:24]=0xA5, mem_wen=1; resp_valid with resp_err=0, rdata=0.
- XLEN=32, load byte signed, addr=0x8000_0002, rsp_rdata=0x1280_3456 -> resp_rdata=0xFFFF_FF80; the same with req_unsigned=1 -> 0x0000_0080; load half at addr 0x...2 -> 0x0000_1280.
- XLEN=32, load half at addr=0x8000_0001 -> resp_valid at cycle 1, resp_err=1, rdata=0, mem_req_valid never asserted; size=3 gives the same result.
- Backpressure: mem_req_ready low for 3 cycles, then resp_ready low for 2 cycles -> mem_* stable across stalls; exactly one handshake on each side; req_ready=0 until the IDLE return.
- Bus error: mem_rsp_err=1 on a load word -> resp_err=1, resp_rdata=0. Reset asserted in WAIT -> IDLE next cycle, all outputs 0, and the late mem_rsp_valid produces no resp_valid.
- XLEN=64, load word signed at addr=0x...4, rsp_rdata=0x8765_4321_0000_0000 -> resp_rdata=0xFFFF_FFFF_8765_4321. Store double at addr=0x...0 -> wmask=8'hFF.

Source files
------------

// File: rtl/lsu.sv
// rtl/lsu.sv - multi-cycle load/store unit with byte-lane steering and error responses
// Sits between decode and a handshaked data-memory bus; one op in flight at a time.
module lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  localparam int MASK_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  input  logic              mem_rsp_err
);
  localparam int OFF_W = $clog2(MASK_W);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wen_q, mem_wen_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0] mem_wmask_q, mem_wmask_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic [2:0]        align_mask;
  logic [MASK_W-1:0] lane_mask;
  logic              bad_req;
  logic [OFF_W-1:0]  req_off;
  logic [XLEN-1:0]   shifted, ext_mask, top_bit, load_data;

  assign req_off = req_addr[OFF_W-1:0];

  always_comb begin
    align_mask = 3'b000;
    lane_mask  = MASK_W'(1);
    case (req_size)
      2'd1: begin align_mask = 3'b001; lane_mask = MASK_W'(3);  end
      2'd2: begin align_mask = 3'b011; lane_mask = MASK_W'(15); end
      2'd3: begin align_mask = 3'b111; lane_mask = '1;          end
      default: ;
    endcase
  end

  assign bad_req = (|(req_addr[2:0] & align_mask)) || ((req_size == 2'd3) && (XLEN == 32));

  // Sign extension from the lane's top bit; a full-width lane has an all-ones mask and passes through.
  always_comb begin
    shifted  = mem_rsp_rdata >> {off_q, 3'b000};
    ext_mask = '1;
    if ((8 << size_q) < XLEN) ext_mask = ~({XLEN{1'b1}} << (8 << size_q));
    top_bit   = ext_mask ^ (ext_mask >> 1);
    load_data = shifted & ext_mask;
    if (!uns_q && (|(shifted & top_bit))) load_data = load_data | ~ext_mask;
  end

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    mem_addr_d   = mem_addr_q;
    mem_wen_d    = mem_wen_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_store_d   = req_is_store;
          size_d       = req_size;
          uns_d        = req_unsigned;
          off_d        = req_off;
          resp_rdata_d = '0;
          resp_err_d   = bad_req;
          if (bad_req) begin
            state_d = RESP;
          end else begin
            state_d     = REQ;
            mem_addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_wen_d   = req_is_store;
            mem_wdata_d = req_wdata << {req_off, 3'b000};
            mem_wmask_d = req_is_store ? (lane_mask << req_off) : '1;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_d      = RESP;
          resp_err_d   = mem_rsp_err;
          resp_rdata_d = (is_store_q || mem_rsp_err) ? '0 : load_data;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      off_q        <= '0;
      mem_addr_q   <= '0;
      mem_wen_q    <= 1'b0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      mem_addr_q   <= mem_addr_d;
      mem_wen_q    <= mem_wen_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Held low while reset is asserted so decode never sees a spurious accept.
  assign req_ready     = rst && (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign resp_valid    = (state_q == RESP);
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;
endmodule
